// File: rtl/trigger_power_detect.sv
// Sliding-window energy trigger: squares NSAMP samples/clock, sums WINDOW_CLKS clocks, fires with holdoff.
// dat_i -> trig_o latency 4 clocks; no backpressure. `define TRIG_PEAK_HOLD_EN adds the peak_o tracker.
module trigger_power_detect #(
  parameter int NSAMP       = 8,
  parameter int NBITS       = 5,
  parameter int WINDOW_CLKS = 4,
  parameter int POWER_W     = 2*NBITS-1+$clog2(NSAMP*WINDOW_CLKS),
  parameter int HOLD_W      = 16
) (
  input  logic                     aclk,
  input  logic                     reset_i,
  input  logic [NSAMP*NBITS-1:0]   dat_i,
  input  logic                     enable_i,
  input  logic [POWER_W-1:0]       thresh_i,
  input  logic [HOLD_W-1:0]        holdoff_i,
  input  logic                     count_clr_i,
  output logic                     trig_o,
  output logic [POWER_W-1:0]       trig_power_o,
  output logic [31:0]              trig_count_o,
  output logic                     busy_o,
  output logic [POWER_W-1:0]       peak_o
);

  localparam int SQ_W   = 2*NBITS-1;
  localparam int LVLS   = $clog2(NSAMP);
  localparam int NP     = 1 << LVLS;
  localparam int CSUM_W = SQ_W + LVLS;

  typedef enum logic {ST_ARMED, ST_HOLDOFF} state_t;

  logic [SQ_W-1:0]    sq_d [NP];
  logic [SQ_W-1:0]    sq_q [NP];
  logic [CSUM_W-1:0]  tree [LVLS+1][NP];
  logic [CSUM_W-1:0]  clk_sum_d, clk_sum_q;
  logic [CSUM_W-1:0]  hist_d [WINDOW_CLKS];
  logic [CSUM_W-1:0]  hist_q [WINDOW_CLKS];
  logic [POWER_W-1:0] win_d, win_q;
  state_t             state_d, state_q;
  logic [HOLD_W-1:0]  hold_cnt_d, hold_cnt_q;
  logic               trig_d, trig_q;
  logic [POWER_W-1:0] trig_power_d, trig_power_q;
  logic [31:0]        trig_count_d, trig_count_q;
  logic               fire;

  // Sign-extend into the product width; the low SQ_W bits of the modular product are the exact square.
  function automatic logic [SQ_W-1:0] square(input logic [NBITS-1:0] s);
    logic [SQ_W-1:0] w;
    w = {{(NBITS-1){s[NBITS-1]}}, s};
    return w * w;
  endfunction

  always_comb begin
    for (int i = 0; i < NP; i++) begin
      sq_d[i] = '0;
      if (i < NSAMP) sq_d[i] = square(dat_i[NBITS*i +: NBITS]);
    end
  end

  always_comb begin
    for (int l = 0; l <= LVLS; l++)
      for (int i = 0; i < NP; i++)
        tree[l][i] = '0;
    for (int i = 0; i < NP; i++)
      tree[0][i] = CSUM_W'(sq_q[i]);
    for (int l = 1; l <= LVLS; l++)
      for (int i = 0; i < NP/2; i++)
        if (i < (NP >> l)) tree[l][i] = tree[l-1][2*i] + tree[l-1][2*i+1];
    clk_sum_d = tree[LVLS][0];
  end

  always_comb begin
    hist_d[0] = clk_sum_q;
    for (int i = 1; i < WINDOW_CLKS; i++)
      hist_d[i] = hist_q[i-1];
    win_d = win_q + POWER_W'(clk_sum_q) - POWER_W'(hist_q[WINDOW_CLKS-1]);
  end

  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    trig_d       = 1'b0;
    trig_power_d = trig_power_q;
    trig_count_d = trig_count_q;
    fire         = 1'b0;
    case (state_q)
      ST_ARMED: begin
        if (enable_i && (win_q > thresh_i)) begin
          fire         = 1'b1;
          trig_d       = 1'b1;
          trig_power_d = win_q;
          hold_cnt_d   = holdoff_i;
          if (holdoff_i != '0) state_d = ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: begin
        hold_cnt_d = hold_cnt_q - 1'b1;
        if (hold_cnt_q == HOLD_W'(1)) state_d = ST_ARMED;
      end
      default: state_d = ST_ARMED;
    endcase
    // A clear that lands on a trigger keeps that trigger in the count.
    if (count_clr_i)
      trig_count_d = fire ? 32'd1 : 32'd0;
    else if (fire && (trig_count_q != 32'hFFFF_FFFF))
      trig_count_d = trig_count_q + 32'd1;
  end

  always_ff @(posedge aclk) begin
    if (reset_i) begin
      for (int i = 0; i < NP; i++) sq_q[i] <= '0;
      for (int i = 0; i < WINDOW_CLKS; i++) hist_q[i] <= '0;
      clk_sum_q    <= '0;
      win_q        <= '0;
      state_q      <= ST_ARMED;
      hold_cnt_q   <= '0;
      trig_q       <= 1'b0;
      trig_power_q <= '0;
      trig_count_q <= '0;
    end else begin
      sq_q         <= sq_d;
      hist_q       <= hist_d;
      clk_sum_q    <= clk_sum_d;
      win_q        <= win_d;
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      trig_q       <= trig_d;
      trig_power_q <= trig_power_d;
      trig_count_q <= trig_count_d;
    end
  end

  assign trig_o       = trig_q;
  assign trig_power_o = trig_power_q;
  assign trig_count_o = trig_count_q;
  assign busy_o       = (state_q == ST_HOLDOFF);

`ifdef TRIG_PEAK_HOLD_EN
  logic [POWER_W-1:0] peak_d, peak_q;

  always_comb begin
    peak_d = peak_q;
    if (count_clr_i)        peak_d = '0;
    else if (win_q > peak_q) peak_d = win_q;
  end

  always_ff @(posedge aclk) begin
    if (reset_i) peak_q <= '0;
    else         peak_q <= peak_d;
  end

  assign peak_o = peak_q;
`else
  assign peak_o = '0;
`endif

endmodule

// File: tb/tb_trigger_power_detect.sv
// Randomised and directed bench for trigger_power_detect against a window-sum / next-allowed-cycle model.
module tb_trigger_power_detect;

  localparam int POWER_W = 14;
  localparam int HOLD_W  = 16;

  logic               aclk = 1'b0;
  logic               reset_i = 1'b1;
  logic [39:0]        dat_i = '0;
  logic               enable_i = 1'b0;
  logic [POWER_W-1:0] thresh_i = '0;
  logic [HOLD_W-1:0]  holdoff_i = '0;
  logic               count_clr_i = 1'b0;
  logic               trig_o;
  logic [POWER_W-1:0] trig_power_o;
  logic [31:0]        trig_count_o;
  logic               busy_o;
  logic [POWER_W-1:0] peak_o;

  always #5 aclk = ~aclk;

  trigger_power_detect dut (
    .aclk         (aclk),
    .reset_i      (reset_i),
    .dat_i        (dat_i),
    .enable_i     (enable_i),
    .thresh_i     (thresh_i),
    .holdoff_i    (holdoff_i),
    .count_clr_i  (count_clr_i),
    .trig_o       (trig_o),
    .trig_power_o (trig_power_o),
    .trig_count_o (trig_count_o),
    .busy_o       (busy_o),
    .peak_o       (peak_o)
  );

  int checks = 0;
  int failures = 0;
  longint cyc = 0;

  // Model: energy of each sampled word, and the first cycle a trigger is allowed again.
  longint eh [7];
  longint next_ok = 0;
  bit     m_trig = 0;
  bit     m_busy = 0;
  longint m_power = 0;
  longint m_count = 0;
  longint m_peak = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic longint energy(input logic [39:0] d);
    longint e;
    logic signed [4:0] v;
    longint sv;
    e = 0;
    for (int k = 0; k < 8; k++) begin
      v  = d[5*k +: 5];
      sv = longint'(v);
      e += sv * sv;
    end
    return e;
  endfunction

  function automatic logic [39:0] rep(input logic [4:0] v);
    return {8{v}};
  endfunction

  task automatic step(input logic rst, input logic [39:0] dat, input logic en,
                      input logic [POWER_W-1:0] th, input logic [HOLD_W-1:0] ho, input logic clr);
    longint wprev;
    reset_i     = rst;
    dat_i       = dat;
    enable_i    = en;
    thresh_i    = th;
    holdoff_i   = ho;
    count_clr_i = clr;
    @(posedge aclk);
    cyc++;
    for (int k = 6; k > 0; k--) eh[k] = eh[k-1];
    eh[0] = energy(dat);
    if (rst) begin
      for (int k = 0; k < 7; k++) eh[k] = 0;
      m_trig = 0; m_power = 0; m_count = 0; m_peak = 0; next_ok = 0;
    end else begin
      // Window seen by this edge's decision: words sampled 3..6 edges ago.
      wprev  = eh[3] + eh[4] + eh[5] + eh[6];
      m_trig = (cyc >= next_ok) && en && (wprev > longint'(th));
      if (m_trig) begin
        m_power = wprev;
        next_ok = cyc + 1 + longint'(ho);
      end
      if (clr) m_count = m_trig ? 1 : 0;
      else if (m_trig && m_count != 64'hFFFF_FFFF) m_count++;
`ifdef TRIG_PEAK_HOLD_EN
      if (clr) m_peak = 0;
      else if (wprev > m_peak) m_peak = wprev;
`endif
    end
    m_busy = (cyc + 1 < next_ok);
    @(negedge aclk);
    check_eq("trig",  64'(trig_o),       64'(m_trig));
    check_eq("busy",  64'(busy_o),       64'(m_busy));
    check_eq("power", 64'(trig_power_o), m_power);
    check_eq("count", 64'(trig_count_o), m_count);
    check_eq("peak",  64'(peak_o),       m_peak);
  endtask

  initial begin
    logic [39:0] d;
    logic [POWER_W-1:0] th;
    for (int k = 0; k < 7; k++) eh[k] = 0;

    // Reset state and idle: zero input never triggers even at threshold 0.
    repeat (3) step(1, '0, 1, 0, 10, 0);
    repeat (100) step(0, '0, 1, 0, 10, 0);

    // Single burst of 15s: window 1800, just above / exactly at threshold.
    step(0, rep(5'd15), 1, 1799, 10, 0);
    repeat (15) step(0, '0, 1, 1799, 10, 0);
    step(0, rep(5'd15), 1, 1800, 10, 0);
    repeat (15) step(0, '0, 1, 1800, 10, 0);

    // Continuous full-scale negative: spaced triggers, then every clock.
    repeat (60) step(0, rep(5'h10), 1, 0, 10, 0);
    repeat (20) step(0, rep(5'h10), 1, 0, 0, 0);

    // Count reaches 5, then a clear coincident with a trigger.
    repeat (2) step(1, '0, 1, 0, 0, 0);
    repeat (8) step(0, rep(5'h10), 1, 0, 0, 0);
    step(0, rep(5'h10), 1, 0, 0, 1);
    repeat (3) step(0, rep(5'h10), 1, 0, 0, 0);

    // Reset in the middle of a long holdoff.
    repeat (20) step(0, rep(5'h10), 1, 0, 1000, 0);
    step(1, rep(5'h10), 1, 0, 1000, 0);
    repeat (12) step(0, rep(5'h10), 1, 0, 1000, 0);

    // Peak tracking over bursts of 3, 7, 5, then a clear.
    step(1, '0, 0, 14'h3FFF, 0, 0);
    step(0, rep(5'd3), 0, 14'h3FFF, 0, 0);
    repeat (10) step(0, '0, 0, 14'h3FFF, 0, 0);
    step(0, rep(5'd7), 0, 14'h3FFF, 0, 0);
    repeat (10) step(0, '0, 0, 14'h3FFF, 0, 0);
    step(0, rep(5'd5), 0, 14'h3FFF, 0, 0);
    repeat (10) step(0, '0, 0, 14'h3FFF, 0, 0);
    step(0, '0, 0, 14'h3FFF, 0, 1);
    repeat (3) step(0, '0, 0, 14'h3FFF, 0, 0);

    // Random traffic with live threshold/holdoff changes, clears and rare resets.
    th = 14'(600);
    for (int n = 0; n < 2000; n++) begin
      d = (($urandom_range(0, 2)) == 0) ? 40'd0 : {$urandom, $urandom};
      if ($urandom_range(0, 15) == 0) th = 14'($urandom_range(0, 6000));
      step($urandom_range(0, 299) == 0, d, $urandom_range(0, 7) != 0, th,
           16'($urandom_range(0, 12)), $urandom_range(0, 39) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
